// File: rtl/serial_adder_nbits.sv
// rtl/serial_adder_nbits.sv - bit-serial N-bit adder, LSB first, one bit per clock
// Result and NZCV-style flags are loaded together on the final bit and held until the next completion.
module serial_adder_nbits #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] result,
    output logic         neg_flag,
    output logic         zr_flag,
    output logic         cry_flag,
    output logic         of_flag,
    output logic         busy,
    output logic         done
);
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADD  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  a_q, a_d;
    logic [N-1:0]  b_q, b_d;
    logic [N-1:0]  sum_q, sum_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          c_q, c_d;
    logic [N-1:0]  result_q, result_d;
    logic          neg_q, neg_d;
    logic          zr_q, zr_d;
    logic          cry_q, cry_d;
    logic          of_q, of_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic          bit_s;
    logic          bit_c;
    logic [N-1:0]  sum_full;

    // Operands shift right so bit 0 is always the current bit; sum bits enter from the top.
    assign bit_s    = a_q[0] ^ b_q[0] ^ c_q;
    assign bit_c    = (a_q[0] & b_q[0]) | (a_q[0] & c_q) | (b_q[0] & c_q);
    assign sum_full = {bit_s, sum_q[N-1:1]};

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        sum_d    = sum_q;
        cnt_d    = cnt_q;
        c_d      = c_q;
        result_d = result_q;
        neg_d    = neg_q;
        zr_d     = zr_q;
        cry_d    = cry_q;
        of_d     = of_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    sum_d   = '0;
                    cnt_d   = '0;
                    c_d     = 1'b0;
                    state_d = S_ADD;
                end
            end
            S_ADD: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                c_d   = bit_c;
                sum_d = sum_full;
                if (cnt_q == LAST_BIT) begin
                    // At the last bit a_q[0]/b_q[0] are the captured sign bits.
                    result_d = sum_full;
                    neg_d    = bit_s;
                    zr_d     = (sum_full == '0);
                    cry_d    = bit_c;
                    of_d     = (a_q[0] == b_q[0]) && (bit_s != a_q[0]);
                    state_d  = S_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d == S_ADD);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            sum_q    <= '0;
            cnt_q    <= '0;
            c_q      <= 1'b0;
            result_q <= '0;
            neg_q    <= 1'b0;
            zr_q     <= 1'b0;
            cry_q    <= 1'b0;
            of_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sum_q    <= sum_d;
            cnt_q    <= cnt_d;
            c_q      <= c_d;
            result_q <= result_d;
            neg_q    <= neg_d;
            zr_q     <= zr_d;
            cry_q    <= cry_d;
            of_q     <= of_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign result   = result_q;
    assign neg_flag = neg_q;
    assign zr_flag  = zr_q;
    assign cry_flag = cry_q;
    assign of_flag  = of_q;
    assign busy     = busy_q;
    assign done     = done_q;
endmodule

// File: tb/tb_serial_adder_nbits.sv
// tb/tb_serial_adder_nbits.sv - randomized and directed bench for serial_adder_nbits against an arithmetic model
module tb_serial_adder_nbits;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] result;
    logic         neg_flag;
    logic         zr_flag;
    logic         cry_flag;
    logic         of_flag;
    logic         busy;
    logic         done;

    int vectors     = 0;
    int miscompares = 0;

    logic [N-1:0] exp_res = '0;
    logic         exp_neg = 1'b0;
    logic         exp_zr  = 1'b0;
    logic         exp_cry = 1'b0;
    logic         exp_of  = 1'b0;

    serial_adder_nbits #(.N(N)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .a        (a),
        .b        (b),
        .result   (result),
        .neg_flag (neg_flag),
        .zr_flag  (zr_flag),
        .cry_flag (cry_flag),
        .of_flag  (of_flag),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Plain integer arithmetic: unsigned sum for result/carry, signed sum range for overflow.
    task automatic model(input int ua, input int ub);
        int s;
        int sa;
        int sb;
        int ss;
        s  = ua + ub;
        sa = (ua >= (1 << (N - 1))) ? ua - (1 << N) : ua;
        sb = (ub >= (1 << (N - 1))) ? ub - (1 << N) : ub;
        ss = sa + sb;
        exp_res = N'(s % (1 << N));
        exp_neg = exp_res[N-1];
        exp_zr  = (s % (1 << N)) == 0;
        exp_cry = s >= (1 << N);
        exp_of  = (ss > (1 << (N - 1)) - 1) || (ss < -(1 << (N - 1)));
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_result"}, result,   exp_res);
        check({tag, "_neg"},    neg_flag, exp_neg);
        check({tag, "_zr"},     zr_flag,  exp_zr);
        check({tag, "_cry"},    cry_flag, exp_cry);
        check({tag, "_of"},     of_flag,  exp_of);
    endtask

    // With noisy set, start stays high and operands churn during ADD/DONE; all of it must be ignored.
    task automatic run_op(input logic [N-1:0] oa, input logic [N-1:0] ob, input bit noisy);
        a     = oa;
        b     = ob;
        start = 1'b1;
        tick();
        model(int'(oa), int'(ob));
        start = 1'b0;
        check("busy_e0", busy, 1);
        check("done_e0", done, 0);
        for (int e = 1; e <= N; e++) begin
            if (noisy) begin
                start = 1'b1;
                a     = (e == 2) ? N'(1) : N'($urandom);
                b     = (e == 2) ? N'(1) : N'($urandom);
            end
            tick();
            if (e < N) begin
                check("busy_add", busy, 1);
                check("done_add", done, 0);
            end
        end
        check("done_pulse", done, 1);
        check("busy_done", busy, 0);
        check_outputs("op");
        tick();
        check("done_cleared", done, 0);
        check("busy_idle", busy, 0);
        check_outputs("hold");
        start = 1'b0;
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check_outputs("rst");

        run_op(4'd3,  4'd4, 1'b0);
        run_op(4'd7,  4'd1, 1'b0);
        run_op(4'd15, 4'd1, 1'b0);
        run_op(4'd8,  4'd8, 1'b0);
        run_op(4'd5,  4'd6, 1'b1);

        // Reset lands on edge 2 of an addition.
        a     = 4'd9;
        b     = 4'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_res = '0;
        exp_neg = 1'b0;
        exp_zr  = 1'b0;
        exp_cry = 1'b0;
        exp_of  = 1'b0;
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check_outputs("midrst");
        for (int i = 0; i < N + 2; i++) begin
            tick();
            check("midrst_no_done", done, 0);
            check("midrst_result", result, 0);
        end
        run_op(4'd9, 4'd3, 1'b0);

        // start held high: one operation per N+2 cycles.
        a     = 4'd2;
        b     = 4'd2;
        start = 1'b1;
        for (int e = 0; e < 12; e++) begin
            tick();
            check("b2b_done", done, (e == N || e == 2 * N + 2) ? 1 : 0);
            check("b2b_busy", busy, ((e < N) || (e >= N + 2 && e < 2 * N + 2)) ? 1 : 0);
            if (e == N || e == 2 * N + 2) begin
                check("b2b_result", result, 4);
            end
        end
        start = 1'b0;
        tick();

        for (int i = 0; i < 40; i++) begin
            run_op(N'($urandom), N'($urandom), 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/serial_adder_nbits.md
SERIAL_ADDER_NBITS -- requirements
Module: serial_adder_nbits

Interface
REQ-001 SHALL have parameter N, default 4, giving the operand and result width in bits (N >= 2).
REQ-002 SHALL have port clk, input, 1 bit, the only clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit, a synchronous active-high reset.
REQ-004 SHALL have port start, input, 1 bit, a request to begin an addition; sampled only in IDLE.
REQ-005 SHALL have port a, input, N bits, the first operand, captured on the accepting edge.
REQ-006 SHALL have port b, input, N bits, the second operand, captured on the accepting edge.
REQ-007 SHALL have port result, output, N bits, the registered sum a+b mod 2^N.
REQ-008 SHALL have port neg_flag, output, 1 bit, a copy of result[N-1].
REQ-009 SHALL have port zr_flag, output, 1 bit, set when result is all zeros.
REQ-010 SHALL have port cry_flag, output, 1 bit, the carry out of bit N-1.
REQ-011 SHALL have port of_flag, output, 1 bit, signed two's-complement overflow.
REQ-012 SHALL have port busy, output, 1 bit, high while the state is ADD.
REQ-013 SHALL have port done, output, 1 bit, a one-cycle completion pulse.

Function
REQ-014 SHALL implement three states, IDLE, ADD and DONE, with IDLE as the reset state.
REQ-015 SHALL, in IDLE with start=1 at an edge, capture a and b into internal registers, clear the internal carry and the bit counter, and enter ADD.
REQ-016 SHALL, in ADD, process exactly one bit per edge, LSB first: sum_i = a_i ^ b_i ^ c; c_next = majority(a_i, b_i, c).
REQ-017 SHALL use a bit counter of width ceil(log2(N)) or wider, incrementing 0..N-1 with no wrap beyond N-1.
REQ-018 SHALL, on the edge that processes bit N-1, load result, neg_flag, zr_flag, cry_flag and of_flag together, and enter DONE.
REQ-019 SHALL assert done for exactly the one cycle spent in DONE, then return to IDLE on the next edge unconditionally.
REQ-020 SHALL give a latency, with the accepting edge as edge 0, of result and flags valid and done=1 after edge N; the next start can be accepted at edge N+2.
REQ-021 SHALL ignore start in ADD or DONE, with no restart and no re-capture of the operands.
REQ-022 SHALL ignore changes on a and b after the accepting edge.
REQ-023 SHALL hold result and all flags stable from the DONE load until the next DONE load.
REQ-024 SHALL compute of_flag = 1 iff a[N-1] == b[N-1] and result[N-1] != a[N-1], using the captured operands.
REQ-025 SHALL make cry_flag equal the carry produced by bit N-1, independent of of_flag.
REQ-026 SHALL leave start held high continuously to produce back-to-back operations, each started from IDLE, one per N+2 cycles.

Reset
REQ-027 SHALL, when rst=1 at an edge, enter IDLE and clear result, neg_flag, zr_flag, cry_flag, of_flag, busy, done, the operand registers, the carry and the counter to 0.
REQ-028 SHALL let rst take priority over start and over any in-progress addition; an operation interrupted mid-ADD is discarded, with no done and no output update.
REQ-029 SHALL keep zr_flag at 0 after reset, even though result=0, until the first completed operation.

Verification (N=4)
REQ-030 SHALL cover: a=3, b=4, start pulse -> after edge 4: result=7, done=1 for one cycle, all flags 0; busy high for cycles 1-4.
REQ-031 SHALL cover: a=7, b=1 -> result=8, neg=1, of=1, cry=0, zr=0.
REQ-032 SHALL cover: a=15, b=1 -> result=0, zr=1, cry=1, of=0, neg=0; then a=8, b=8 -> result=0, zr=1, cry=1, of=1.
REQ-033 SHALL cover: a=5, b=6 started, then start=1 with a=1, b=1 at edge 2 -> ignored; result=11 (neg=1, of=1) at edge 4.
REQ-034 SHALL cover: rst=1 at edge 2 of an addition -> busy=0, done never pulses, result and flags 0; a new start then completes normally.
REQ-035 SHALL cover: start held high for 12 cycles with a=2, b=2 -> done pulses at edges 4 and 10, result=4 each time.
